// File: rtl/ysyx_23060203_ifu_fq_if.sv
// Fetch-queue IFU bus: the ICache lookup port, the redirect input and the IDU-facing queue head.
// The master side belongs to the IFU and the slave side to its environment.
interface ysyx_23060203_ifu_fq_if #(
    parameter int FQ_DEPTH = 4
) ();
    localparam int CW = $clog2(FQ_DEPTH + 1);

    logic [31:0]   fetch_addr;
    logic          fetch_hit;
    logic [31:0]   fetch_inst;
    logic          flush;
    logic [31:0]   flush_dnpc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic          out_pred_taken;
    logic [CW-1:0] fq_count;

    modport master (
        output fetch_addr,
        input  fetch_hit, fetch_inst, flush, flush_dnpc,
        output out_valid,
        input  out_ready,
        output out_pc, out_inst, out_pred_taken, fq_count
    );

    modport slave (
        input  fetch_addr,
        output fetch_hit, fetch_inst, flush, flush_dnpc,
        input  out_valid,
        output out_ready,
        input  out_pc, out_inst, out_pred_taken, fq_count
    );
endinterface

// File: rtl/ysyx_23060203_ifu_fq.sv
// Instruction fetch unit with static next-PC prediction and a circular fetch queue toward the IDU.
// Redirects empty the queue; a redirect that lands during a cache miss is parked until the miss returns.
module ysyx_23060203_ifu_fq #(
    parameter int          FQ_DEPTH  = 4,
    parameter logic [31:0] RESET_PC  = 32'h3000_0000,
    parameter int          PRED_MODE = 1,
    parameter int          STALL_SYS = 1
) (
    input  logic clock,
    input  logic reset,
    ysyx_23060203_ifu_fq_if.master bus
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);

    logic [31:0]         r_fetch_pc;
    logic [31:0]         r_dnpc;
    logic                r_flush_pend;
    logic                r_sys_hold;
    logic [PW-1:0]       r_head;
    logic [PW-1:0]       r_tail;
    logic [CW-1:0]       r_count;
    logic [31:0]         r_pc_mem   [FQ_DEPTH];
    logic [31:0]         r_inst_mem [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] r_pt_mem;

    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_incr;
    logic        w_is_sys;
    logic        w_pred_taken;
    logic        w_pop;
    logic        w_push;

    assign w_imm_b = {{19{bus.fetch_inst[31]}}, bus.fetch_inst[31], bus.fetch_inst[7],
                      bus.fetch_inst[30:25], bus.fetch_inst[11:8], 1'b0};
    assign w_imm_j = {{11{bus.fetch_inst[31]}}, bus.fetch_inst[31], bus.fetch_inst[19:12],
                      bus.fetch_inst[20], bus.fetch_inst[30:21], 1'b0};

    // Static next-PC increment selected from the opcode of the instruction being fetched.
    always_comb begin
        w_incr   = 32'd4;
        w_is_sys = 1'b0;
        case (bus.fetch_inst[6:2])
            5'b11000: begin
                if ((PRED_MODE == 1) && bus.fetch_inst[31]) begin
                    w_incr = w_imm_b;
                end else begin
                    w_incr = 32'd4;
                end
            end
            5'b11011: begin
                if (PRED_MODE == 1) begin
                    w_incr = w_imm_j;
                end else begin
                    w_incr = 32'd4;
                end
            end
            5'b11100: begin
                if (STALL_SYS == 1) begin
                    w_incr   = 32'd0;
                    w_is_sys = 1'b1;
                end else begin
                    w_incr   = 32'd4;
                end
            end
            default: w_incr = 32'd4;
        endcase
    end

    // A zero increment is the SYSTEM self-hold, not a taken prediction.
    assign w_pred_taken = (w_incr != 32'd4) && (w_incr != 32'd0);

    assign bus.out_valid = (r_count != CW'(0)) & ~bus.flush;
    assign w_pop         = bus.out_valid & bus.out_ready;
    assign w_push        = bus.fetch_hit & ~bus.flush & ~r_flush_pend & ~r_sys_hold &
                           ((r_count < CW'(FQ_DEPTH)) | w_pop);

    // Fetch PC, deferred redirect target and the SYSTEM stall flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc   <= RESET_PC;
            r_dnpc       <= 32'd0;
            r_flush_pend <= 1'b0;
            r_sys_hold   <= 1'b0;
        end else if (bus.flush) begin
            r_sys_hold <= 1'b0;
            if (bus.fetch_hit) begin
                r_fetch_pc   <= bus.flush_dnpc;
                r_flush_pend <= 1'b0;
            end else begin
                r_flush_pend <= 1'b1;
                r_dnpc       <= bus.flush_dnpc;
            end
        end else if (r_flush_pend) begin
            if (bus.fetch_hit) begin
                r_fetch_pc   <= r_dnpc;
                r_flush_pend <= 1'b0;
            end
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + w_incr;
            if (w_is_sys) begin
                r_sys_hold <= 1'b1;
            end
        end
    end

    // Queue pointers and occupancy; pointers wrap at their natural width.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= PW'(0);
            r_tail  <= PW'(0);
            r_count <= CW'(0);
        end else if (bus.flush) begin
            r_head  <= r_tail;
            r_count <= CW'(0);
        end else begin
            r_head <= r_head + PW'(w_pop);
            r_tail <= r_tail + PW'(w_push);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage, written at the tail on every push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_pc_mem[i]   <= 32'd0;
                r_inst_mem[i] <= 32'd0;
            end
            r_pt_mem <= '0;
        end else if (w_push) begin
            r_pc_mem[r_tail]   <= r_fetch_pc;
            r_inst_mem[r_tail] <= bus.fetch_inst;
            r_pt_mem[r_tail]   <= w_pred_taken;
        end
    end

    assign bus.fetch_addr     = r_fetch_pc;
    assign bus.out_pc         = r_pc_mem[r_head];
    assign bus.out_inst       = r_inst_mem[r_head];
    assign bus.out_pred_taken = r_pt_mem[r_head];
    assign bus.fq_count       = r_count;
endmodule
